// File: rtl/spi_byte_receiver.sv
// SPI mode-0 byte receiver: brings raw SPI pins into the system clock domain,
// assembles MSB-first bytes from MOSI and returns reply bytes on MISO.
`timescale 1ns/1ps
module spi_byte_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       IO_main_clk,
  input  logic       IO_main_rst_n,
  input  logic       IO_SPI_sck,
  input  logic       IO_SPI_mosi,
  input  logic       IO_SPI_ss_n,
  output logic       IO_SPI_miso,
  output logic [7:0] IO_SPI_data,
  output logic       IO_SPI_data_ready,
  output logic       IO_SPI_cs,
  output logic       IO_SPI_abort,
  output logic [7:0] IO_SPI_frame_bytes
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;

  logic       sck_s;
  logic       mosi_s;
  logic       ss_s;
  logic       sck_prev;
  logic       ss_prev;
  logic       sck_rise;
  logic       sck_fall;
  logic       ss_fall;
  logic       ss_rise;
  logic       rx_en;
  logic       byte_done;
  logic [2:0] bit_cnt;
  logic [7:0] shift_rx;
  logic [7:0] rx_byte;
  logic [7:0] tx;

  // ss_n idles high so its synchroniser resets to the deselected level
  always_ff @(posedge IO_main_clk or negedge IO_main_rst_n) begin
    if (!IO_main_rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], IO_SPI_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], IO_SPI_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], IO_SPI_ss_n};
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign sck_rise  = ~sck_prev & sck_s;
  assign sck_fall  = sck_prev & ~sck_s;
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign rx_en     = sck_rise & ~ss_s;
  assign byte_done = rx_en & (bit_cnt == 3'd7);
  assign rx_byte   = {shift_rx[6:0], mosi_s};

  always_ff @(posedge IO_main_clk or negedge IO_main_rst_n) begin
    if (!IO_main_rst_n) begin
      sck_prev <= 1'b0;
      ss_prev  <= 1'b1;
      bit_cnt  <= 3'd0;
      shift_rx <= 8'h00;
    end else begin
      sck_prev <= sck_s;
      ss_prev  <= ss_s;
      if (ss_s) begin
        bit_cnt  <= 3'd0;
        shift_rx <= 8'h00;
      end else if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_rx <= rx_byte;
      end
    end
  end

  always_ff @(posedge IO_main_clk or negedge IO_main_rst_n) begin
    if (!IO_main_rst_n) begin
      IO_SPI_data        <= 8'h00;
      IO_SPI_data_ready  <= 1'b0;
      IO_SPI_abort       <= 1'b0;
      IO_SPI_frame_bytes <= 8'h00;
      tx                 <= 8'h00;
    end else begin
      IO_SPI_data_ready <= byte_done;
      IO_SPI_abort      <= ss_rise & (bit_cnt != 3'd0);
      if (byte_done) begin
        IO_SPI_data <= rx_byte;
      end
      if (ss_fall) begin
        IO_SPI_frame_bytes <= 8'h00;
      end else if (byte_done && IO_SPI_frame_bytes != 8'hFF) begin
        IO_SPI_frame_bytes <= IO_SPI_frame_bytes + 8'd1;
      end
      // no shift on the fall at a byte boundary: the freshly loaded byte's MSB must stay on MISO
      if (ss_fall) begin
        tx <= IO_SPI_data;
      end else if (byte_done) begin
        tx <= rx_byte;
      end else if (sck_fall && !ss_s && bit_cnt != 3'd0) begin
        tx <= {tx[6:0], 1'b0};
      end
    end
  end

  assign IO_SPI_cs   = ss_s;
  assign IO_SPI_miso = ss_s ? 1'b1 : tx[7];

endmodule
